// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory stage: single-outstanding data bus access and writeback formatting
// Optional feature macro: MEM_MISALIGN_CHK_EN (misaligned H/HU/W accesses complete without a bus request)
module mem_access #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            EE_valid_i,
    input  logic [XLEN-1:0] EE_valE_i,
    input  logic [XLEN-1:0] EE_rs2_data_i,
    input  logic            EE_op_load_i,
    input  logic            EE_op_store_i,
    input  logic [2:0]      EE_funct3_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_wstrb_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            M_valid_o,
    output logic [XLEN-1:0] M_valM_o,
    output logic            M_stall_o,
    output logic            M_bus_err_o,
    output logic            M_misalign_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          state_nx;
    logic [7:0]      cnt;
    logic            complete;
    logic            timeout;

    // Decoded view of the instruction currently held in the E/M register
    logic            start;
    logic [1:0]      off_d;
    logic [1:0]      size_d;
    logic            sign_d;
    logic [XLEN-1:0] addr_d;
    logic [3:0]      wstrb_d;
    logic [XLEN-1:0] wdata_d;
    logic            mis_d;

    // Registers captured when an access leaves IDLE
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wstrb_q;
    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic            sign_q;
    logic            we_q;
    logic [XLEN-1:0] res_q;
    logic            err_q;
    logic            mis_q;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_val;

    // Decode size/sign, strobes and lane-replicated store data of the incoming access
    always_comb begin
        start  = EE_valid_i & (EE_op_load_i | EE_op_store_i);
        off_d  = EE_valE_i[1:0];
        sign_d = ~EE_funct3_i[2];
        addr_d = {EE_valE_i[XLEN-1:2], 2'b00};
        case (EE_funct3_i[1:0])
            2'b00:   size_d = SZ_B;
            2'b01:   size_d = SZ_H;
            default: size_d = SZ_W;
        endcase
        wstrb_d = 4'b0000;
        wdata_d = '0;
        if (EE_op_store_i) begin
            case (size_d)
                SZ_B: begin
                    wstrb_d = 4'b0001 << off_d;
                    wdata_d = {(XLEN/8){EE_rs2_data_i[7:0]}};
                end
                SZ_H: begin
                    wstrb_d = 4'b0011 << off_d;
                    wdata_d = {(XLEN/16){EE_rs2_data_i[15:0]}};
                end
                default: begin
                    wstrb_d = 4'b1111;
                    wdata_d = EE_rs2_data_i;
                end
            endcase
        end
`ifdef MEM_MISALIGN_CHK_EN
        mis_d = ((size_d == SZ_H) && off_d[0]) || ((size_d == SZ_W) && (off_d != 2'b00));
`else
        mis_d = 1'b0;
`endif
    end

    // Select and extend the addressed lane of the returned load word
    always_comb begin
        ld_byte = dmem_rdata_i[{off_q, 3'b000} +: 8];
        ld_half = dmem_rdata_i[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_B:    ld_val = {{(XLEN-8){sign_q & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_val = {{(XLEN-16){sign_q & ld_half[15]}}, ld_half};
            default: ld_val = dmem_rdata_i;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and all outputs; reset forces every output low immediately
    always_comb begin
        state_nx     = state;
        complete     = 1'b0;
        timeout      = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_wstrb_o = 4'b0000;
        dmem_wdata_o = '0;
        M_valid_o    = 1'b0;
        M_valM_o     = '0;
        M_stall_o    = 1'b0;
        M_bus_err_o  = 1'b0;
        M_misalign_o = 1'b0;
        if (state == ST_IDLE) begin
            if (start) begin
                dmem_we_o    = EE_op_store_i;
                dmem_addr_o  = addr_d;
                dmem_wstrb_o = wstrb_d;
                dmem_wdata_o = wdata_d;
            end
        end else begin
            dmem_we_o    = we_q;
            dmem_addr_o  = addr_q;
            dmem_wstrb_o = wstrb_q;
            dmem_wdata_o = wdata_q;
        end
        case (state)
            ST_IDLE: begin
                if (start) begin
                    M_stall_o = 1'b1;
                    state_nx  = mis_d ? ST_DONE : ST_REQ;
                end else begin
                    M_valid_o = EE_valid_i;
                    M_valM_o  = EE_valE_i;
                end
            end
            ST_REQ: begin
                dmem_req_o = 1'b1;
                M_stall_o  = 1'b1;
                if (dmem_gnt_i && dmem_rvalid_i) begin
                    complete = 1'b1;
                    state_nx = ST_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout  = 1'b1;
                    state_nx = ST_DONE;
                end else if (dmem_gnt_i) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                M_stall_o = 1'b1;
                if (dmem_rvalid_i) begin
                    complete = 1'b1;
                    state_nx = ST_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout  = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            default: begin
                M_valid_o    = 1'b1;
                M_valM_o     = res_q;
                M_bus_err_o  = err_q;
                M_misalign_o = mis_q;
                state_nx     = ST_IDLE;
            end
        endcase
        if (rst) begin
            dmem_req_o   = 1'b0;
            dmem_we_o    = 1'b0;
            dmem_addr_o  = '0;
            dmem_wstrb_o = 4'b0000;
            dmem_wdata_o = '0;
            M_valid_o    = 1'b0;
            M_valM_o     = '0;
            M_stall_o    = 1'b0;
            M_bus_err_o  = 1'b0;
            M_misalign_o = 1'b0;
        end
    end

    // Timeout counter: runs across REQ and WAIT, cleared whenever the access leaves them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if ((state == ST_REQ || state == ST_WAIT) &&
                     (state_nx == ST_REQ || state_nx == ST_WAIT)) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= 8'd0;
        end
    end

    // Capture the access on issue, then the formatted result or error on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
            off_q   <= 2'b00;
            size_q  <= SZ_B;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            we_q    <= EE_op_store_i;
            res_q   <= '0;
            err_q   <= 1'b0;
            mis_q   <= mis_d;
        end else if (complete) begin
            res_q   <= we_q ? '0 : ld_val;
        end else if (timeout) begin
            res_q   <= '0;
            err_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access against a transaction-level model
module tb_mem_access;

    localparam int XLEN = 32;
    localparam int T    = 255;
    localparam int NEVER = 100000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ee_valid = 1'b0;
    logic [31:0]     ee_vale = '0;
    logic [31:0]     ee_rs2 = '0;
    logic            ee_load = 1'b0;
    logic            ee_store = 1'b0;
    logic [2:0]      ee_f3 = 3'b000;
    logic            dmem_req;
    logic            dmem_we;
    logic [31:0]     dmem_addr;
    logic [3:0]      dmem_wstrb;
    logic [31:0]     dmem_wdata;
    logic            dmem_gnt = 1'b0;
    logic            dmem_rvalid = 1'b0;
    logic [31:0]     dmem_rdata = '0;
    logic            m_valid;
    logic [31:0]     m_valm;
    logic            m_stall;
    logic            m_bus_err;
    logic            m_misalign;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access #(.XLEN(XLEN), .TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .EE_valid_i   (ee_valid),
        .EE_valE_i    (ee_vale),
        .EE_rs2_data_i(ee_rs2),
        .EE_op_load_i (ee_load),
        .EE_op_store_i(ee_store),
        .EE_funct3_i  (ee_f3),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wstrb_o (dmem_wstrb),
        .dmem_wdata_o (dmem_wdata),
        .dmem_gnt_i   (dmem_gnt),
        .dmem_rvalid_i(dmem_rvalid),
        .dmem_rdata_i (dmem_rdata),
        .M_valid_o    (m_valid),
        .M_valM_o     (m_valm),
        .M_stall_o    (m_stall),
        .M_bus_err_o  (m_bus_err),
        .M_misalign_o (m_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int o;
        logic [31:0] v;
        o = int'(a[1:0]);
        if (f3 == 3'b000 || f3 == 3'b100) begin
            v = (rd >> (8 * o)) & 32'hFF;
            if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
            v = (rd >> (16 * (o / 2))) & 32'hFFFF;
            if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
        int o;
        o = int'(a[1:0]);
        if (f3 == 3'b000) return 4'((1 << o) & 15);
        if (f3 == 3'b001) return 4'((3 << o) & 15);
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        if (f3 == 3'b000) return (rs2 & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'b001) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    task automatic alu_op(input string nm, input bit v, input logic [31:0] val);
        tick();
        ee_valid = v; ee_load = 1'b0; ee_store = 1'b0; ee_vale = val;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        settle();
        chk({nm, ".valid"}, m_valid, v);
        if (v) chk({nm, ".valM"}, m_valm, val);
        chk({nm, ".stall"}, m_stall, 0);
        chk({nm, ".req"}, dmem_req, 0);
    endtask

    // One memory instruction from issue through DONE; gnt_at/rv_at are cycles after issue
    task automatic mem_txn(input string nm, input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rs2, input int gnt_at, input int rv_at,
                           input logic [31:0] rd, input bit noise);
        int done;
        bit to;
        bit mis;
        logic [31:0] v;
        mis = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
        mis = misaligned(f3, a);
`endif
        if (mis) begin
            done = 1; to = 1'b0; v = '0;
        end else if (gnt_at <= T && rv_at <= T) begin
            done = rv_at + 1; to = 1'b0; v = st ? 32'h0 : exp_load(f3, a, rd);
        end else begin
            done = T + 1; to = 1'b1; v = '0;
        end
        tick();
        ee_valid = 1'b1; ee_load = !st; ee_store = st; ee_f3 = f3; ee_vale = a; ee_rs2 = rs2;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = rd;
        settle();
        chk({nm, ".c0.stall"}, m_stall, 1);
        chk({nm, ".c0.valid"}, m_valid, 0);
        chk({nm, ".c0.req"}, dmem_req, 0);
        for (int c = 1; c <= done; c++) begin
            tick();
            dmem_gnt    = (c == gnt_at) && (c < done);
            dmem_rvalid = ((c == rv_at) && (c < done)) ||
                          (noise && (c < gnt_at) && (c < done) && ($urandom_range(0, 1) == 1));
            settle();
            if (c < done) begin
                chk({nm, ".stall"}, m_stall, 1);
                chk({nm, ".valid"}, m_valid, 0);
                chk({nm, ".req"}, dmem_req, (c <= gnt_at));
                if (c <= gnt_at) begin
                    chk({nm, ".addr"}, dmem_addr, a & 32'hFFFF_FFFC);
                    chk({nm, ".we"}, dmem_we, st);
                    chk({nm, ".wstrb"}, dmem_wstrb, st ? exp_strb(f3, a) : 4'h0);
                    if (st) chk({nm, ".wdata"}, dmem_wdata, exp_wdata(f3, rs2));
                end
            end else begin
                chk({nm, ".done.valid"}, m_valid, 1);
                chk({nm, ".done.stall"}, m_stall, 0);
                chk({nm, ".done.req"}, dmem_req, 0);
                chk({nm, ".done.valM"}, m_valm, v);
                chk({nm, ".done.err"}, m_bus_err, to);
                chk({nm, ".done.mis"}, m_misalign, mis);
            end
        end
        tick();
        ee_valid = 1'b0; ee_load = 1'b0; ee_store = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        settle();
        chk({nm, ".idle.valid"}, m_valid, 0);
        chk({nm, ".idle.stall"}, m_stall, 0);
        chk({nm, ".idle.req"}, dmem_req, 0);
    endtask

    initial begin
        // reset state, with an ALU op presented while reset is held
        ee_valid = 1'b1; ee_vale = 32'h55;
        #2;
        chk("rst.valid", m_valid, 0);
        chk("rst.valM", m_valm, 0);
        chk("rst.stall", m_stall, 0);
        chk("rst.req", dmem_req, 0);
        chk("rst.err", m_bus_err, 0);
        chk("rst.mis", m_misalign, 0);
        chk("rst.wstrb", dmem_wstrb, 0);
        tick();
        rst = 1'b0; ee_valid = 1'b0;

        alu_op("alu1234", 1'b1, 32'h1234);
        alu_op("bubble", 1'b0, 32'hDEAD_BEEF);
        mem_txn("lb103", 1'b0, 3'b000, 32'h103, 32'h0, 2, 4, 32'h80FF_0000, 1'b0);
        mem_txn("sh202", 1'b1, 3'b001, 32'h202, 32'hABCD_5678, 1, 1, 32'h0, 1'b0);
        mem_txn("sb_hi", 1'b1, 3'b000, 32'h307, 32'h0000_00A5, 3, 5, 32'h0, 1'b1);
        mem_txn("sh_o3", 1'b1, 3'b001, 32'h403, 32'h0000_BEEF, 1, 2, 32'h0, 1'b0);
        mem_txn("lw_to_wait", 1'b0, 3'b010, 32'h40, 32'h0, 1, NEVER, 32'h1111_2222, 1'b0);
        mem_txn("lw_to_req", 1'b0, 3'b010, 32'h44, 32'h0, NEVER, NEVER, 32'h3333_4444, 1'b1);
        mem_txn("lw_6", 1'b0, 3'b010, 32'h6, 32'h0, 1, 2, 32'hCAFE_F00D, 1'b0);

        // reset while in WAIT, then a late rvalid in IDLE
        tick();
        ee_valid = 1'b1; ee_load = 1'b1; ee_store = 1'b0; ee_f3 = 3'b010; ee_vale = 32'h10;
        settle();
        tick();
        dmem_gnt = 1'b1;
        settle();
        tick();
        dmem_gnt = 1'b0;
        settle();
        chk("wait.stall", m_stall, 1);
        chk("wait.req", dmem_req, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort.valid", m_valid, 0);
        chk("abort.stall", m_stall, 0);
        chk("abort.req", dmem_req, 0);
        chk("abort.valM", m_valm, 0);
        chk("abort.addr", dmem_addr, 0);
        chk("abort.we", dmem_we, 0);
        tick();
        rst = 1'b0; ee_valid = 1'b0; ee_load = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        settle();
        chk("late_rv.valid", m_valid, 0);
        chk("late_rv.stall", m_stall, 0);
        chk("late_rv.req", dmem_req, 0);
        tick();
        dmem_rvalid = 1'b0;
        settle();
        chk("late_rv2.valid", m_valid, 0);
        chk("late_rv2.stall", m_stall, 0);
        mem_txn("lhu6", 1'b0, 3'b101, 32'h6, 32'h0, 1, 1, 32'h8001_0000, 1'b0);
        mem_txn("lh2", 1'b0, 3'b001, 32'h2, 32'h0, 1, 3, 32'h8001_0000, 1'b0);

        // randomized mix of ALU ops and accesses
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                alu_op("r_alu", 1'($urandom_range(0, 1)), $urandom);
            end else begin
                bit st;
                logic [2:0] f3;
                int g;
                int r;
                st = 1'($urandom_range(0, 1));
                f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
                g = $urandom_range(1, 4);
                r = g + $urandom_range(0, 3);
                mem_txn(st ? "r_st" : "r_ld", st, f3, $urandom, $urandom, g, r, $urandom,
                        1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
